// File: rtl/vector_loader.sv
// Decodes a command byte from the UART stream and streams LENGTH bytes into SIPO bank A or B.
// Latency: 1 cycle from rx_ready to the write strobe / cmd_valid, all outputs registered.
// Backpressure: none. Every rx_ready byte is consumed, and a stalled load aborts after TIMEOUT idle cycles.
module vector_loader #(
  parameter int WIDTH   = 8,
  parameter int LENGTH  = 1024,
  parameter int TIMEOUT = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] ser_out,
  output logic             write_a,
  output logic             write_b,
  output logic [WIDTH-1:0] cmd,
  output logic             cmd_valid,
  output logic             busy,
  output logic             load_done,
  output logic             load_abort
);

  localparam int CW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]    LAST_IDX  = CW'(LENGTH - 1);
  localparam logic [TW-1:0]    TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] CMD_LOAD_A = WIDTH'(1);
  localparam logic [WIDTH-1:0] CMD_LOAD_B = WIDTH'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [TW-1:0] timer;

  // Command decode, byte streaming into the selected bank, and idle-timeout abort.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      timer      <= '0;
      ser_out    <= '0;
      cmd        <= '0;
      write_a    <= 1'b0;
      write_b    <= 1'b0;
      cmd_valid  <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_abort <= 1'b0;
    end else begin
      // Strobes are one cycle wide unless re-asserted below.
      write_a    <= 1'b0;
      write_b    <= 1'b0;
      cmd_valid  <= 1'b0;
      load_done  <= 1'b0;
      load_abort <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          count <= '0;
          if (rx_ready) begin
            if (rx_data == CMD_LOAD_A) begin
              state <= LOAD_A;
              busy  <= 1'b1;
            end else if (rx_data == CMD_LOAD_B) begin
              state <= LOAD_B;
              busy  <= 1'b1;
            end else begin
              cmd       <= rx_data;
              cmd_valid <= 1'b1;
            end
          end
        end
        LOAD_A, LOAD_B: begin
          // A byte arriving on the expiry cycle takes priority over the abort.
          if (rx_ready) begin
            ser_out <= rx_data;
            timer   <= '0;
            if (state == LOAD_A) write_a <= 1'b1;
            else                 write_b <= 1'b1;
            if (count == LAST_IDX) begin
              load_done <= 1'b1;
              count     <= '0;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              count <= count + CW'(1);
            end
          end else if (timer == TIMER_MAX) begin
            // Partial SIPO contents are left in place; the host reloads.
            load_abort <= 1'b1;
            count      <= '0;
            timer      <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader with LENGTH=8, TIMEOUT=16.
module tb_vector_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [7:0] ser_out;
  logic       write_a;
  logic       write_b;
  logic [7:0] cmd;
  logic       cmd_valid;
  logic       busy;
  logic       load_done;
  logic       load_abort;

  int checks   = 0;
  int failures = 0;

  // Pulse tallies sampled on the falling edge.
  int na = 0, nb = 0, ndone = 0, nabort = 0, ncmd = 0, nboth = 0;

  vector_loader #(.WIDTH(8), .LENGTH(8), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
    .ser_out(ser_out), .write_a(write_a), .write_b(write_b), .cmd(cmd),
    .cmd_valid(cmd_valid), .busy(busy), .load_done(load_done), .load_abort(load_abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_a) na++;
    if (write_b) nb++;
    if (load_done) ndone++;
    if (load_abort) nabort++;
    if (cmd_valid) ncmd++;
    if (write_a && write_b) nboth++;
  end

  // One rx_ready strobe; returns 1 ns after the sampling edge so outputs show this byte.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; rx_ready = 1'b0; rx_data = 8'h00;
    idle(2);
    checks++;
    if ({ser_out, cmd} !== 16'h0000 || {write_a, write_b, cmd_valid, busy, load_done, load_abort} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got ser_out=%h cmd=%h strobes=%b exp all zero", ser_out, cmd,
               {write_a, write_b, cmd_valid, busy, load_done, load_abort});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_load_a;
    int a0, b0, d0;
    a0 = na; b0 = nb; d0 = ndone;
    send_byte(8'h01);
    checks++;
    if (busy !== 1'b1 || write_a !== 1'b0) begin
      failures++;
      $display("FAIL t1_enter got busy=%b write_a=%b exp busy=1 write_a=0", busy, write_a);
    end
    for (int i = 0; i < 8; i++) begin
      send_byte(8'h10 + 8'(i));
      checks++;
      if (write_a !== 1'b1 || write_b !== 1'b0 || ser_out !== 8'h10 + 8'(i) ||
          load_done !== (i == 7) || busy !== (i != 7)) begin
        failures++;
        $display("FAIL t1_byte%0d got wa=%b wb=%b ser=%h done=%b busy=%b exp wa=1 wb=0 ser=%h done=%b busy=%b",
                 i, write_a, write_b, ser_out, load_done, busy, 8'h10 + 8'(i), (i == 7), (i != 7));
      end
      idle(1);
      checks++;
      if (write_a !== 1'b0 || ser_out !== 8'h10 + 8'(i) || load_done !== 1'b0) begin
        failures++;
        $display("FAIL t1_gap%0d got wa=%b ser=%h done=%b exp wa=0 ser=%h done=0",
                 i, write_a, ser_out, load_done, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (na - a0 !== 8 || nb - b0 !== 0 || ndone - d0 !== 1) begin
      failures++;
      $display("FAIL t1_counts got a=%0d b=%0d done=%0d exp a=8 b=0 done=1", na - a0, nb - b0, ndone - d0);
    end
  endtask

  task automatic test_back_to_back;
    int a0, b0;
    a0 = na; b0 = nb;
    send_byte(8'h02);
    for (int i = 0; i < 8; i++) begin
      rx_data  = 8'hA0 + 8'(i);
      rx_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (write_b !== 1'b1 || write_a !== 1'b0 || ser_out !== 8'hA0 + 8'(i) || load_done !== (i == 7)) begin
        failures++;
        $display("FAIL t2_byte%0d got wb=%b wa=%b ser=%h done=%b exp wb=1 wa=0 ser=%h done=%b",
                 i, write_b, write_a, ser_out, load_done, 8'hA0 + 8'(i), (i == 7));
      end
    end
    rx_ready = 1'b0;
    idle(1);
    checks++;
    if (nb - b0 !== 8 || na - a0 !== 0 || busy !== 1'b0 || write_b !== 1'b0) begin
      failures++;
      $display("FAIL t2_end got b=%0d a=%0d busy=%b wb=%b exp b=8 a=0 busy=0 wb=0", nb - b0, na - a0, busy, write_b);
    end
  endtask

  task automatic test_forward;
    int a0, b0;
    a0 = na; b0 = nb;
    send_byte(8'h5C);
    checks++;
    if (cmd !== 8'h5C || cmd_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t3_cmd got cmd=%h vld=%b busy=%b exp cmd=5c vld=1 busy=0", cmd, cmd_valid, busy);
    end
    idle(1);
    checks++;
    if (cmd !== 8'h5C || cmd_valid !== 1'b0 || na != a0 || nb != b0) begin
      failures++;
      $display("FAIL t3_after got cmd=%h vld=%b writes=%0d exp cmd=5c vld=0 writes=0",
               cmd, cmd_valid, (na - a0) + (nb - b0));
    end
    send_byte(8'h00);
    checks++;
    if (cmd !== 8'h00 || cmd_valid !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t3_zero got cmd=%h vld=%b busy=%b exp cmd=00 vld=1 busy=0", cmd, cmd_valid, busy);
    end
    idle(1);
  endtask

  task automatic test_timeout;
    int a0, d0;
    send_byte(8'h01);
    for (int i = 0; i < 3; i++) send_byte(8'h30 + 8'(i));
    for (int j = 1; j <= 15; j++) begin
      idle(1);
      checks++;
      if (load_abort !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL t4_wait%0d got abort=%b busy=%b exp abort=0 busy=1", j, load_abort, busy);
      end
    end
    idle(1);
    checks++;
    if (load_abort !== 1'b1 || busy !== 1'b0 || dut.count !== 3'd0 || write_a !== 1'b0) begin
      failures++;
      $display("FAIL t4_abort got abort=%b busy=%b count=%0d wa=%b exp abort=1 busy=0 count=0 wa=0",
               load_abort, busy, dut.count, write_a);
    end
    idle(1);
    checks++;
    if (load_abort !== 1'b0) begin
      failures++;
      $display("FAIL t4_abort_width got abort=%b exp 0", load_abort);
    end
    a0 = na; d0 = ndone;
    send_byte(8'h01);
    for (int i = 0; i < 8; i++) send_byte(8'h50 + 8'(i));
    checks++;
    if (load_done !== 1'b1 || ser_out !== 8'h57 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t4_reload got done=%b ser=%h busy=%b exp done=1 ser=57 busy=0", load_done, ser_out, busy);
    end
    idle(1);
    checks++;
    if (na - a0 !== 8 || ndone - d0 !== 1) begin
      failures++;
      $display("FAIL t4_reload_counts got a=%0d done=%0d exp a=8 done=1", na - a0, ndone - d0);
    end
  endtask

  task automatic test_reset_mid_load;
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    reset = 1'b1;
    #2;
    checks++;
    if ({ser_out, cmd} !== 16'h0000 || {write_a, write_b, cmd_valid, busy, load_done, load_abort} !== 6'b0) begin
      failures++;
      $display("FAIL t5_in_reset got ser_out=%h cmd=%h strobes=%b exp all zero", ser_out, cmd,
               {write_a, write_b, cmd_valid, busy, load_done, load_abort});
    end
    idle(3);
    checks++;
    if (busy !== 1'b0 || write_b !== 1'b0 || dut.count !== 3'd0) begin
      failures++;
      $display("FAIL t5_hold got busy=%b wb=%b count=%0d exp 0 0 0", busy, write_b, dut.count);
    end
    reset = 1'b0;
    idle(1);
    send_byte(8'h07);
    checks++;
    if (cmd !== 8'h07 || cmd_valid !== 1'b1 || busy !== 1'b0 || write_b !== 1'b0) begin
      failures++;
      $display("FAIL t5_cmd got cmd=%h vld=%b busy=%b wb=%b exp cmd=07 vld=1 busy=0 wb=0",
               cmd, cmd_valid, busy, write_b);
    end
    idle(1);
  endtask

  task automatic test_byte_wins;
    int ab0;
    ab0 = nabort;
    send_byte(8'h01);
    send_byte(8'h40);
    idle(15);
    send_byte(8'h41);
    checks++;
    if (write_a !== 1'b1 || ser_out !== 8'h41 || load_abort !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t6_edge got wa=%b ser=%h abort=%b busy=%b exp wa=1 ser=41 abort=0 busy=1",
               write_a, ser_out, load_abort, busy);
    end
    idle(15);
    checks++;
    if (busy !== 1'b1 || nabort != ab0) begin
      failures++;
      $display("FAIL t6_timer_cleared got busy=%b aborts=%0d exp busy=1 aborts=0", busy, nabort - ab0);
    end
    for (int i = 2; i < 8; i++) send_byte(8'h40 + 8'(i));
    checks++;
    if (load_done !== 1'b1 || ser_out !== 8'h47 || busy !== 1'b0) begin
      failures++;
      $display("FAIL t6_done got done=%b ser=%h busy=%b exp done=1 ser=47 busy=0", load_done, ser_out, busy);
    end
    idle(1);
    checks++;
    if (nboth != 0) begin
      failures++;
      $display("FAIL both_writes got %0d cycles exp 0", nboth);
    end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_back_to_back();
    test_forward();
    test_timeout();
    test_reset_mid_load();
    test_byte_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
